// File: rtl/baccarat_pkg.sv
// Shared types and rules for the multi-hand baccarat shoe sequencer.
// banker_draws() is reused by the score datapath bench.
package baccarat_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StP1,
    StD1,
    StP2,
    StD2,
    StEval,
    StP3,
    StEval3,
    StD3,
    StScore,
    StHold,
    StDone
  } state_e;

  localparam logic [3:0] NATURAL = 4'd8;

  // Banker third-card decision once the player has drawn a third card.
  function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] pcard3);
    case (dscore)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return (pcard3 != 4'd8);
      4'd4:             return (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             return (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             return (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/baccarat_shoe_fsm.sv
// Sequences card loads for a shoe of baccarat hands, applies third-card rules,
// drives win lights and keeps saturating win/loss/tie tallies.
module baccarat_shoe_fsm
  import baccarat_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 8,
  parameter int unsigned TALLY_W     = 4,
  parameter int unsigned AUTO_NEXT   = 0,
  parameter int unsigned HOLD_CYCLES = 4,
  localparam int unsigned RIDX_W     = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic               i_slow_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_next_round,
  input  logic               i_card_valid,
  input  logic [3:0]         i_pscore,
  input  logic [3:0]         i_dscore,
  input  logic [3:0]         i_pcard3,
  output logic               o_load_pcard1,
  output logic               o_load_pcard2,
  output logic               o_load_pcard3,
  output logic               o_load_dcard1,
  output logic               o_load_dcard2,
  output logic               o_load_dcard3,
  output logic               o_new_round,
  output logic               o_player_win_light,
  output logic               o_dealer_win_light,
  output logic [TALLY_W-1:0] o_player_wins,
  output logic [TALLY_W-1:0] o_dealer_wins,
  output logic [TALLY_W-1:0] o_ties,
  output logic [RIDX_W-1:0]  o_round_idx,
  output logic               o_shoe_done
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e              r_state;
  logic [RIDX_W-1:0]   r_round_idx;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_new_round;
  logic                r_player_light;
  logic                r_dealer_light;
  logic                r_shoe_done;

  logic w_natural;
  logic w_hold_exit;
  logic w_in_score;
  logic w_tally_clr;
  logic w_last_round;

  // Out-of-range scores (10-15) fall into the natural branch as well.
  assign w_natural    = (i_pscore >= NATURAL) || (i_dscore >= NATURAL);
  assign w_hold_exit  = (AUTO_NEXT != 0) ? (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1))
                                         : i_next_round;
  assign w_in_score   = (r_state == StScore);
  assign w_tally_clr  = (r_state == StDone) && i_start;
  assign w_last_round = (r_round_idx == RIDX_W'(NUM_ROUNDS - 1));

  always_ff @(posedge i_slow_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_round_idx    <= '0;
      r_hold_cnt     <= '0;
      r_new_round    <= 1'b0;
      r_player_light <= 1'b0;
      r_dealer_light <= 1'b0;
      r_shoe_done    <= 1'b0;
    end else begin
      r_new_round <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state     <= StP1;
            r_round_idx <= '0;
            r_new_round <= 1'b1;
            r_shoe_done <= 1'b0;
          end
        end
        StP1: if (i_card_valid) r_state <= StD1;
        StD1: if (i_card_valid) r_state <= StP2;
        StP2: if (i_card_valid) r_state <= StD2;
        StD2: if (i_card_valid) r_state <= StEval;
        StEval: begin
          if (w_natural)               r_state <= StScore;
          else if (i_pscore <= 4'd5)   r_state <= StP3;
          else if (i_dscore <= 4'd5)   r_state <= StD3;
          else                         r_state <= StScore;
        end
        StP3: if (i_card_valid) r_state <= StEval3;
        StEval3: r_state <= banker_draws(i_dscore, i_pcard3) ? StD3 : StScore;
        StD3: if (i_card_valid) r_state <= StScore;
        StScore: begin
          r_state        <= StHold;
          r_hold_cnt     <= '0;
          r_player_light <= (i_pscore >= i_dscore);
          r_dealer_light <= (i_dscore >= i_pscore);
        end
        StHold: begin
          if (w_hold_exit) begin
            r_player_light <= 1'b0;
            r_dealer_light <= 1'b0;
            if (w_last_round) begin
              r_state     <= StDone;
              r_shoe_done <= 1'b1;
            end else begin
              r_state     <= StP1;
              r_round_idx <= r_round_idx + 1'b1;
              r_new_round <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Load strobes double as the card_valid acknowledge.
  assign o_load_pcard1 = (r_state == StP1) && i_card_valid;
  assign o_load_dcard1 = (r_state == StD1) && i_card_valid;
  assign o_load_pcard2 = (r_state == StP2) && i_card_valid;
  assign o_load_dcard2 = (r_state == StD2) && i_card_valid;
  assign o_load_pcard3 = (r_state == StP3) && i_card_valid;
  assign o_load_dcard3 = (r_state == StD3) && i_card_valid;

  assign o_new_round        = r_new_round;
  assign o_player_win_light = r_player_light;
  assign o_dealer_win_light = r_dealer_light;
  assign o_round_idx        = r_round_idx;
  assign o_shoe_done        = r_shoe_done;

  sat_counter #(.W(TALLY_W)) u_player_tally (
    .i_clk   (i_slow_clock),
    .i_rst   (i_reset),
    .i_clr   (w_tally_clr),
    .i_inc   (w_in_score && (i_pscore > i_dscore)),
    .o_count (o_player_wins)
  );

  sat_counter #(.W(TALLY_W)) u_dealer_tally (
    .i_clk   (i_slow_clock),
    .i_rst   (i_reset),
    .i_clr   (w_tally_clr),
    .i_inc   (w_in_score && (i_dscore > i_pscore)),
    .o_count (o_dealer_wins)
  );

  sat_counter #(.W(TALLY_W)) u_tie_tally (
    .i_clk   (i_slow_clock),
    .i_rst   (i_reset),
    .i_clr   (w_tally_clr),
    .i_inc   (w_in_score && (i_dscore == i_pscore)),
    .o_count (o_ties)
  );

endmodule

// File: tb/tb_baccarat_shoe_fsm.sv
// Directed bench for baccarat_shoe_fsm: three instances (manual 8-hand, auto 2-hand,
// auto 2-bit tallies) with a scoreboard of expected hand outcomes.
module tb_baccarat_shoe_fsm;

  typedef struct {
    int lat;
    bit pl;
    bit dl;
    int pw;
    int dw;
    int tw;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic       next_round;
  logic       cv;
  logic [3:0] ps, ds, pc3;

  logic [5:0] ld_a, ld_b, ld_c;
  logic [2:0] nr, pl, dl, sd;
  logic [3:0] pw_a, dw_a, tw_a, pw_b, dw_b, tw_b;
  logic [1:0] pw_c, dw_c, tw_c;
  logic [2:0] ri_a, ri_c;
  logic       ri_b;

  int   sel;
  logic [5:0] m_ld;
  logic m_nr, m_pl, m_dl, m_sd;
  int   m_pw, m_dw, m_tw, m_ri;

  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];
  int   e_pw[3], e_dw[3], e_tw[3], e_ri[3];

  always #5 clk = ~clk;

  baccarat_shoe_fsm #(.NUM_ROUNDS(8), .TALLY_W(4), .AUTO_NEXT(0), .HOLD_CYCLES(4)) u_dut_a (
    .i_slow_clock(clk), .i_reset(rst), .i_start(st[0]), .i_next_round(next_round),
    .i_card_valid(cv), .i_pscore(ps), .i_dscore(ds), .i_pcard3(pc3),
    .o_load_pcard1(ld_a[0]), .o_load_dcard1(ld_a[1]), .o_load_pcard2(ld_a[2]),
    .o_load_dcard2(ld_a[3]), .o_load_pcard3(ld_a[4]), .o_load_dcard3(ld_a[5]),
    .o_new_round(nr[0]), .o_player_win_light(pl[0]), .o_dealer_win_light(dl[0]),
    .o_player_wins(pw_a), .o_dealer_wins(dw_a), .o_ties(tw_a),
    .o_round_idx(ri_a), .o_shoe_done(sd[0])
  );

  baccarat_shoe_fsm #(.NUM_ROUNDS(2), .TALLY_W(4), .AUTO_NEXT(1), .HOLD_CYCLES(4)) u_dut_b (
    .i_slow_clock(clk), .i_reset(rst), .i_start(st[1]), .i_next_round(next_round),
    .i_card_valid(cv), .i_pscore(ps), .i_dscore(ds), .i_pcard3(pc3),
    .o_load_pcard1(ld_b[0]), .o_load_dcard1(ld_b[1]), .o_load_pcard2(ld_b[2]),
    .o_load_dcard2(ld_b[3]), .o_load_pcard3(ld_b[4]), .o_load_dcard3(ld_b[5]),
    .o_new_round(nr[1]), .o_player_win_light(pl[1]), .o_dealer_win_light(dl[1]),
    .o_player_wins(pw_b), .o_dealer_wins(dw_b), .o_ties(tw_b),
    .o_round_idx(ri_b), .o_shoe_done(sd[1])
  );

  baccarat_shoe_fsm #(.NUM_ROUNDS(8), .TALLY_W(2), .AUTO_NEXT(1), .HOLD_CYCLES(1)) u_dut_c (
    .i_slow_clock(clk), .i_reset(rst), .i_start(st[2]), .i_next_round(next_round),
    .i_card_valid(cv), .i_pscore(ps), .i_dscore(ds), .i_pcard3(pc3),
    .o_load_pcard1(ld_c[0]), .o_load_dcard1(ld_c[1]), .o_load_pcard2(ld_c[2]),
    .o_load_dcard2(ld_c[3]), .o_load_pcard3(ld_c[4]), .o_load_dcard3(ld_c[5]),
    .o_new_round(nr[2]), .o_player_win_light(pl[2]), .o_dealer_win_light(dl[2]),
    .o_player_wins(pw_c), .o_dealer_wins(dw_c), .o_ties(tw_c),
    .o_round_idx(ri_c), .o_shoe_done(sd[2])
  );

  always_comb begin
    m_ld = ld_a; m_nr = nr[0]; m_pl = pl[0]; m_dl = dl[0]; m_sd = sd[0];
    m_pw = 32'(pw_a); m_dw = 32'(dw_a); m_tw = 32'(tw_a); m_ri = 32'(ri_a);
    if (sel == 1) begin
      m_ld = ld_b; m_nr = nr[1]; m_pl = pl[1]; m_dl = dl[1]; m_sd = sd[1];
      m_pw = 32'(pw_b); m_dw = 32'(dw_b); m_tw = 32'(tw_b); m_ri = 32'(ri_b);
    end else if (sel == 2) begin
      m_ld = ld_c; m_nr = nr[2]; m_pl = pl[2]; m_dl = dl[2]; m_sd = sd[2];
      m_pw = 32'(pw_c); m_dw = 32'(dw_c); m_tw = 32'(tw_c); m_ri = 32'(ri_c);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Banker rule table, written as per-score masks of allowed third-card values.
  function automatic bit bank_rule(input int d, input int c);
    logic [15:0] m;
    case (d)
      0, 1, 2: m = 16'hFFFF;
      3:       m = 16'hFEFF;
      4:       m = 16'h00FC;
      5:       m = 16'h00F0;
      6:       m = 16'h00C0;
      default: m = 16'h0000;
    endcase
    return m[c[3:0]];
  endfunction

  function automatic int sat_inc(input int v, input int u);
    int mx;
    mx = (u == 2) ? 3 : 15;
    return (v < mx) ? v + 1 : v;
  endfunction

  // One hand: eval-time scores pe/de, final scores pf/df applied once D3 loads.
  task automatic run_hand(input int u, input bit do_start, input int pe, input int de,
                          input int c3, input int pf, input int df, input bit stall);
    exp_t e;
    int   n, scnt;
    bit   stalled, done, p3, d3, nat;
    int   cnt[6];
    sel = u;
    ps = 4'(pe); ds = 4'(de); pc3 = 4'(c3); cv = 1'b1;
    nat = (pe >= 8) || (de >= 8);
    p3  = !nat && (pe <= 5);
    d3  = p3 ? bank_rule(de, c3) : (!nat && (de <= 5));
    if (do_start) begin
      e_pw[u] = 0; e_dw[u] = 0; e_tw[u] = 0; e_ri[u] = 0;
    end
    if (pf > df) e_pw[u] = sat_inc(e_pw[u], u);
    else if (df > pf) e_dw[u] = sat_inc(e_dw[u], u);
    else e_tw[u] = sat_inc(e_tw[u], u);
    e.lat = 6 + (p3 ? 2 : 0) + (d3 ? 1 : 0) + (stall ? 3 : 0);
    e.pl = (pf >= df); e.dl = (df >= pf);
    e.pw = e_pw[u]; e.dw = e_dw[u]; e.tw = e_tw[u];
    sb.push_back(e);

    if (do_start) begin
      st[u] = 1'b1;
      step();
      st[u] = 1'b0;
      chk("start_tally_clear", m_pw + m_dw + m_tw, 0);
    end
    chk("new_round", m_nr, 1);
    chk("round_idx", m_ri, e_ri[u]);
    for (int i = 0; i < 6; i++) cnt[i] = int'(m_ld[i]);
    n = 0; scnt = 0; stalled = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      n++;
      if (scnt > 0) begin
        chk("stall_no_pcard2", m_ld[2], 0);
        scnt--;
        if (scnt == 0) begin
          cv = 1'b1;
          #1;
        end
      end else if (stall && !stalled && m_ld[2]) begin
        cv = 1'b0; stalled = 1'b1; scnt = 3;
        #1;
        chk("stall_no_pcard2", m_ld[2], 0);
      end
      if (m_ld[5]) begin
        ps = 4'(pf); ds = 4'(df);
      end
      for (int i = 0; i < 6; i++) cnt[i] += int'(m_ld[i]);
      if (m_pl || m_dl) done = 1'b1;
    end
    chk("lights_seen", done, 1);
    e = sb.pop_front();
    chk("light_latency", n, e.lat);
    chk("player_light", m_pl, e.pl);
    chk("dealer_light", m_dl, e.dl);
    chk("player_wins", m_pw, e.pw);
    chk("dealer_wins", m_dw, e.dw);
    chk("ties", m_tw, e.tw);
    for (int i = 0; i < 4; i++) chk($sformatf("strobe%0d_count", i), cnt[i], 1);
    chk("pcard3_count", cnt[4], p3 ? 1 : 0);
    chk("dcard3_count", cnt[5], d3 ? 1 : 0);
  endtask

  task automatic next_a();
    sel = 0;
    next_round = 1'b1;
    step();
    next_round = 1'b0;
    chk("next_lights_off", m_pl | m_dl, 0);
    e_ri[0]++;
  endtask

  task automatic auto_wait(input int u, input int h, input bit last);
    sel = u;
    for (int k = 1; k <= h; k++) begin
      step();
      if (k < h) chk("hold_light_kept", m_pl | m_dl, 1);
    end
    chk("hold_exit_lights_off", m_pl | m_dl, 0);
    if (last) begin
      chk("shoe_done", m_sd, 1);
      chk("done_round_idx", m_ri, e_ri[u]);
      chk("done_no_new_round", m_nr, 0);
    end else begin
      chk("auto_new_round", m_nr, 1);
      e_ri[u]++;
    end
  endtask

  initial begin
    rst = 1'b1; st = 3'b000; next_round = 1'b0; cv = 1'b0;
    ps = 4'd0; ds = 4'd0; pc3 = 4'd0; sel = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_strobes", m_ld, 0);
    chk("reset_lights", {m_pl, m_dl, m_nr, m_sd}, 0);
    chk("reset_tallies", m_pw + m_dw + m_tw + m_ri, 0);
    #1 rst = 1'b0;
    step();

    // Manual-advance shoe on instance A.
    run_hand(0, 1, 8, 3, 0, 8, 3, 0);          // natural, player
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    chk("start_ignored_in_hold", m_pl, 1);
    chk("start_ignored_no_new_round", m_nr, 0);
    next_a();
    run_hand(0, 0, 5, 6, 6, 7, 7, 0);          // both draw, tie
    next_a();
    run_hand(0, 0, 3, 9, 0, 3, 9, 1);          // natural with P2 stall, dealer
    next_a();
    run_hand(0, 0, 6, 4, 0, 6, 4, 0);          // banker-only draw, player
    next_a();
    run_hand(0, 0, 2, 7, 5, 2, 7, 0);          // player draws, banker stands
    next_a();
    run_hand(0, 0, 12, 0, 0, 12, 0, 0);        // out-of-range score as natural

    // Reset asserted while in D2.
    next_a();
    step(); step(); step();
    chk("in_d2_strobe", m_ld, 6'b001000);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_strobes", m_ld, 0);
    chk("async_reset_lights", {m_pl, m_dl, m_nr, m_sd}, 0);
    chk("async_reset_tallies", m_pw + m_dw + m_tw, 0);
    chk("async_reset_round_idx", m_ri, 0);
    #1 rst = 1'b0;
    step();
    chk("post_reset_idle_strobes", m_ld, 0);
    chk("post_reset_no_new_round", m_nr, 0);

    // Two-hand auto-advance shoe on instance B, then a fresh shoe from DONE.
    run_hand(1, 1, 9, 1, 0, 9, 1, 0);
    auto_wait(1, 4, 0);
    run_hand(1, 0, 1, 9, 0, 1, 9, 0);
    auto_wait(1, 4, 1);
    step();
    chk("done_stays", m_sd, 1);
    run_hand(1, 1, 4, 4, 8, 4, 4, 0);

    // Dealer wins five hands on a 2-bit tally.
    for (int k = 0; k < 5; k++) begin
      run_hand(2, (k == 0), 0, 9, 0, 0, 9, 0);
      auto_wait(2, 1, 0);
    end
    chk("dealer_tally_saturated", m_dw, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
